// File: rtl/washing_machine_ctrl.sv
// ---------------------------------------------------------------------------
// washing_machine_ctrl
//
// Multi-mode washing-machine sequencer. One run is
//   FILL -> WASH -> DRAIN_W -> [RFILL -> RINSE -> DRAIN_R] x R -> SPIN -> DONE
// Each phase length comes from a cycle-count parameter. The wash length and
// the rinse count R depend on the mode that is latched when start is accepted.
// Mode 11 (rinse+spin) starts directly at RFILL with R = 1.
//
// abort forces an emergency drain (ABORT_DRAIN) followed by IDLE, and no done
// pulse is produced.
//
// Optional feature, built only when the macro WM_PAUSE_EN is defined:
//   pause/resume. The PAUSE state holds the return state and the phase count.
//   Without the macro the pause port is present but ignored, and state code 9
//   is handled like any other unused code.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   start      in   level, sampled only in IDLE
//   mode[1:0]  in   00 light, 01 normal, 10 heavy, 11 rinse+spin
//   abort      in   level, forces the emergency drain
//   pause      in   level, used only with WM_PAUSE_EN
//   state[3:0] out  current state code
//   fill, wash, rinse, spin, drain  out  actuator enables
//   door_lock  out  high in every state except IDLE
//   busy       out  high whenever the state is not IDLE
//   done       out  one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module washing_machine_ctrl #(
  parameter int CNT_W      = 16,
  parameter int FILL_CYC   = 4,
  parameter int WASH_L_CYC = 6,
  parameter int WASH_N_CYC = 8,
  parameter int WASH_H_CYC = 10,
  parameter int DRAIN_CYC  = 3,
  parameter int RINSE_CYC  = 5,
  parameter int SPIN_CYC   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       abort,
  input  logic       pause,
  output logic [3:0] state,
  output logic       fill,
  output logic       wash,
  output logic       rinse,
  output logic       spin,
  output logic       drain,
  output logic       door_lock,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FILL    = 4'd1,
    S_WASH    = 4'd2,
    S_DRAIN_W = 4'd3,
    S_RFILL   = 4'd4,
    S_RINSE   = 4'd5,
    S_DRAIN_R = 4'd6,
    S_SPIN    = 4'd7,
    S_DONE    = 4'd8,
    S_PAUSE   = 4'd9,
    S_ABORT   = 4'd10
  } state_t;

  // Phase counters stop at length-1, so a phase lasts exactly `length` cycles.
  localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0] WASH_L_LAST = CNT_W'(WASH_L_CYC - 1);
  localparam logic [CNT_W-1:0] WASH_N_LAST = CNT_W'(WASH_N_CYC - 1);
  localparam logic [CNT_W-1:0] WASH_H_LAST = CNT_W'(WASH_H_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] RINSE_LAST  = CNT_W'(RINSE_CYC - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST   = CNT_W'(SPIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = 1;

  state_t           cur_state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [1:0]       rinse_cnt, nxt_rinse_cnt;
  logic [1:0]       mode_q, nxt_mode;

  logic [CNT_W-1:0] wash_last;
  logic [CNT_W-1:0] phase_last;
  logic             phase_end;
  logic [1:0]       rinse_total;
  state_t           adv_state;
  logic [CNT_W-1:0] adv_cnt;
  logic [1:0]       adv_rinse;

`ifdef WM_PAUSE_EN
  state_t saved_state, nxt_saved;
`else
  logic unused_pause;
  assign unused_pause = pause;
`endif

  // State, phase counter, rinse counter and latched mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state   <= S_IDLE;
      cnt         <= '0;
      rinse_cnt   <= 2'd0;
      mode_q      <= 2'b00;
`ifdef WM_PAUSE_EN
      saved_state <= S_IDLE;
`endif
    end else begin
      cur_state   <= nxt_state;
      cnt         <= nxt_cnt;
      rinse_cnt   <= nxt_rinse_cnt;
      mode_q      <= nxt_mode;
`ifdef WM_PAUSE_EN
      saved_state <= nxt_saved;
`endif
    end
  end

  // Mode-dependent wash length and rinse count, taken from the latched mode.
  always_comb begin
    wash_last   = WASH_N_LAST;
    rinse_total = 2'd1;
    case (mode_q)
      2'b00: begin wash_last = WASH_L_LAST; rinse_total = 2'd1; end
      2'b01: begin wash_last = WASH_N_LAST; rinse_total = 2'd2; end
      2'b10: begin wash_last = WASH_H_LAST; rinse_total = 2'd3; end
      default: begin wash_last = WASH_N_LAST; rinse_total = 2'd1; end
    endcase
  end

  // Last count value of the phase currently running.
  always_comb begin
    phase_last = '0;
    case (cur_state)
      S_FILL, S_RFILL:               phase_last = FILL_LAST;
      S_WASH:                        phase_last = wash_last;
      S_DRAIN_W, S_DRAIN_R, S_ABORT: phase_last = DRAIN_LAST;
      S_RINSE:                       phase_last = RINSE_LAST;
      S_SPIN:                        phase_last = SPIN_LAST;
      default:                       phase_last = '0;
    endcase
  end

  assign phase_end = (cnt == phase_last);

  // Undisturbed advance of the run sequence. Pause saves exactly this
  // result, so the cycle on which pause is sampled still counts as elapsed
  // phase time, and a pause on a phase's last cycle resumes into the next
  // phase.
  always_comb begin
    adv_state = cur_state;
    adv_rinse = rinse_cnt;
    case (cur_state)
      S_FILL:    if (phase_end) adv_state = S_WASH;
      S_WASH:    if (phase_end) adv_state = S_DRAIN_W;
      S_DRAIN_W: if (phase_end) adv_state = S_RFILL;
      S_RFILL:   if (phase_end) adv_state = S_RINSE;
      S_RINSE:   if (phase_end) adv_state = S_DRAIN_R;
      S_DRAIN_R: begin
        if (phase_end) begin
          adv_rinse = rinse_cnt + 2'd1;
          if (({1'b0, rinse_cnt} + 3'd1) < {1'b0, rinse_total}) begin
            adv_state = S_RFILL;
          end else begin
            adv_state = S_SPIN;
          end
        end
      end
      S_SPIN:    if (phase_end) adv_state = S_DONE;
      default:   adv_state = cur_state;
    endcase
    if (adv_state == cur_state) begin
      adv_cnt = cnt + CNT_ONE;
    end else begin
      adv_cnt = '0;
    end
  end

  // Next-state selection. The priority is abort, then pause, then the
  // normal advance.
  always_comb begin
    nxt_state     = cur_state;
    nxt_cnt       = cnt;
    nxt_rinse_cnt = rinse_cnt;
    nxt_mode      = mode_q;
`ifdef WM_PAUSE_EN
    nxt_saved     = saved_state;
`endif
    case (cur_state)
      S_IDLE: begin
        nxt_cnt = '0;
        if (start) begin
          nxt_mode      = mode;
          nxt_rinse_cnt = 2'd0;
          if (mode == 2'b11) begin
            nxt_state = S_RFILL;
          end else begin
            nxt_state = S_FILL;
          end
        end
      end
      S_FILL, S_WASH, S_DRAIN_W, S_RFILL, S_RINSE, S_DRAIN_R, S_SPIN: begin
        if (abort) begin
          nxt_state = S_ABORT;
          nxt_cnt   = '0;
`ifdef WM_PAUSE_EN
        end else if (pause) begin
          nxt_state     = S_PAUSE;
          nxt_saved     = adv_state;
          nxt_cnt       = adv_cnt;
          nxt_rinse_cnt = adv_rinse;
`endif
        end else begin
          nxt_state     = adv_state;
          nxt_cnt       = adv_cnt;
          nxt_rinse_cnt = adv_rinse;
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
      end
      S_ABORT: begin
        if (phase_end) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
`ifdef WM_PAUSE_EN
      S_PAUSE: begin
        if (abort) begin
          nxt_state = S_ABORT;
          nxt_cnt   = '0;
        end else if (!pause) begin
          nxt_state = saved_state;
        end
      end
`endif
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    fill      = (cur_state == S_FILL) || (cur_state == S_RFILL);
    wash      = (cur_state == S_WASH);
    rinse     = (cur_state == S_RINSE);
    spin      = (cur_state == S_SPIN);
    drain     = (cur_state == S_DRAIN_W) || (cur_state == S_DRAIN_R) ||
                (cur_state == S_ABORT);
    done      = (cur_state == S_DONE);
    door_lock = (cur_state != S_IDLE);
    busy      = (cur_state != S_IDLE);
  end

  assign state = cur_state;

endmodule
